// File: rtl/floppy_reg_pkg.sv
// rtl/floppy_reg_pkg.sv - address map, control bits and decode helper for floppy_reg_bank
package floppy_reg_pkg;

   localparam int SP_W = 22;

   localparam logic [5:0] ADDR_NOTE_BASE = 6'h00;
   localparam logic [5:0] ADDR_DUR_BASE  = 6'h10;
   localparam logic [5:0] ADDR_EXP       = 6'h3D;
   localparam logic [5:0] ADDR_STATUS    = 6'h3E;
   localparam logic [5:0] ADDR_CTRL      = 6'h3F;

   localparam int CTRL_MUTE   = 0;
   localparam int CTRL_FREEZE = 1;
   localparam int NOTE_EN     = 7;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_NOTE,
      REG_DUR,
      REG_EXP,
      REG_STATUS,
      REG_CTRL
   } reg_kind_e;

   typedef struct packed {
      reg_kind_e  kind;
      logic [3:0] ch;
   } reg_dec_t;

   function automatic reg_dec_t decode_addr(input logic [5:0] addr, input int n_ch);
      reg_dec_t d;
      d.kind = REG_NONE;
      d.ch   = addr[3:0];
      if ((addr[5:4] == ADDR_NOTE_BASE[5:4]) && (int'(addr[3:0]) < n_ch)) begin
         d.kind = REG_NOTE;
      end else if ((addr[5:4] == ADDR_DUR_BASE[5:4]) && (int'(addr[3:0]) < n_ch)) begin
         d.kind = REG_DUR;
      end else if (addr == ADDR_EXP) begin
         d.kind = REG_EXP;
      end else if (addr == ADDR_STATUS) begin
         d.kind = REG_STATUS;
      end else if (addr == ADDR_CTRL) begin
         d.kind = REG_CTRL;
      end
      return d;
   endfunction

endpackage

// File: rtl/floppy_lookup.sv
// rtl/floppy_lookup.sv - MIDI note to floppy step half-period (clocks at 50 MHz)
module floppy_lookup (
   input  logic [6:0]  i_note,
   output logic [21:0] o_sp
);

   logic [3:0]  w_oct;
   logic [3:0]  w_semi;
   logic [21:0] w_base;

   assign w_oct  = 4'(i_note / 7'd12);
   assign w_semi = 4'(i_note % 7'd12);

   // Half-periods of MIDI octave -1 (notes 0..11); higher octaves halve per step.
   always_comb begin
      w_base = 22'd3057805;
      case (w_semi)
         4'd0:    w_base = 22'd3057805;
         4'd1:    w_base = 22'd2886184;
         4'd2:    w_base = 22'd2724195;
         4'd3:    w_base = 22'd2571297;
         4'd4:    w_base = 22'd2426944;
         4'd5:    w_base = 22'd2290730;
         4'd6:    w_base = 22'd2162161;
         4'd7:    w_base = 22'd2040808;
         4'd8:    w_base = 22'd1926267;
         4'd9:    w_base = 22'd1818182;
         4'd10:   w_base = 22'd1716135;
         4'd11:   w_base = 22'd1619816;
         default: w_base = 22'd3057805;
      endcase
   end

   assign o_sp = w_base >> w_oct;

endmodule

// File: rtl/floppy_note_timer.sv
// rtl/floppy_note_timer.sv - per-channel note-duration countdown with expire pulse
module floppy_note_timer #(
   parameter int DUR_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_tick,
   input  logic             i_load,
   input  logic [DUR_W-1:0] i_load_val,
   input  logic             i_clear,
   input  logic             i_freeze,
   output logic             o_running,
   output logic             o_expire
);

   logic [DUR_W-1:0] r_cnt;
   logic             r_running;
   logic             w_step;

   // A register write to this channel in the same cycle overrides the countdown.
   assign w_step    = i_tick & r_running & ~i_freeze & ~i_load & ~i_clear;
   assign o_expire  = w_step & (r_cnt == DUR_W'(1));
   assign o_running = r_running;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt     <= '0;
         r_running <= 1'b0;
      end else if (i_load) begin
         if (i_load_val != '0) begin
            r_cnt     <= i_load_val;
            r_running <= 1'b1;
         end else begin
            r_running <= 1'b0;
         end
      end else if (i_clear) begin
         r_running <= 1'b0;
      end else if (w_step) begin
         r_cnt <= r_cnt - DUR_W'(1);
         if (r_cnt == DUR_W'(1)) begin
            r_running <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/floppy_reg_bank.sv
// rtl/floppy_reg_bank.sv - MIDI-floppy register bank with per-channel note timers
// Optional sticky expiry flags and irq output with FLOPPY_REG_IRQ_EN.
module floppy_reg_bank
   import floppy_reg_pkg::*;
#(
   parameter int N_CH    = 4,
   parameter int CLK_HZ  = 50000000,
   parameter int TICK_HZ = 1000,
   parameter int DUR_W   = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [5:0]             reg_addr,
   input  logic                   write,
   input  logic                   new_req,
   input  logic [7:0]             write_value,
   output logic [7:0]             read_value,
   output logic                   read_valid,
   output logic [7:0]             led,
   output logic [SP_W*N_CH-1:0]   f_sp,
   output logic [N_CH-1:0]        f_en
`ifdef FLOPPY_REG_IRQ_EN
   ,
   output logic                   irq
`endif
);

   localparam int DIV  = CLK_HZ / TICK_HZ;
   localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int N_ST = (N_CH < 8) ? N_CH : 8;

   logic [PW-1:0]    r_presc;
   logic             w_tick;
   reg_dec_t         w_dec;
   logic             w_wr;
   logic             w_rd;
   logic [7:0]       r_note [N_CH];
   logic [DUR_W-1:0] r_dur  [N_CH];
   logic [7:0]       r_ctrl;
   logic [N_CH-1:0]  w_note_wr;
   logic [N_CH-1:0]  w_dur_wr;
   logic [N_CH-1:0]  w_running;
   logic [N_CH-1:0]  w_expire;
   logic [7:0]       w_status;
   logic [7:0]       w_rdata;

   assign w_dec  = decode_addr(reg_addr, N_CH);
   assign w_wr   = new_req & write;
   assign w_rd   = new_req & ~write;
   assign w_tick = (r_presc == PW'(DIV - 1));
   assign led    = r_note[0];

   // Free-running tick source; freeze only gates the channel countdowns.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + PW'(1);
      end
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      assign w_note_wr[c] = w_wr && (w_dec.kind == REG_NOTE) && (w_dec.ch == 4'(c));
      assign w_dur_wr[c]  = w_wr && (w_dec.kind == REG_DUR) && (w_dec.ch == 4'(c));

      floppy_note_timer #(
         .DUR_W (DUR_W)
      ) u_timer (
         .i_clk      (clk),
         .i_rst_n    (rst_n),
         .i_tick     (w_tick),
         .i_load     (w_note_wr[c] & write_value[NOTE_EN]),
         .i_load_val (r_dur[c]),
         .i_clear    (w_note_wr[c] & ~write_value[NOTE_EN]),
         .i_freeze   (r_ctrl[CTRL_FREEZE]),
         .o_running  (w_running[c]),
         .o_expire   (w_expire[c])
      );

      floppy_lookup u_lookup (
         .i_note (r_note[c][6:0]),
         .o_sp   (f_sp[c*SP_W +: SP_W])
      );

      assign f_en[c] = r_note[c][NOTE_EN] & ~r_ctrl[CTRL_MUTE];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < N_CH; c++) begin
            r_note[c] <= '0;
            r_dur[c]  <= '0;
         end
         r_ctrl <= '0;
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            if (w_note_wr[c]) begin
               r_note[c] <= write_value;
            end else if (w_expire[c]) begin
               r_note[c][NOTE_EN] <= 1'b0;
            end
            if (w_dur_wr[c]) begin
               r_dur[c] <= DUR_W'(write_value);
            end
         end
         if (w_wr && (w_dec.kind == REG_CTRL)) begin
            r_ctrl <= write_value;
         end
      end
   end

`ifdef FLOPPY_REG_IRQ_EN
   logic [N_CH-1:0] r_exp;
   logic [N_CH-1:0] w_exp_clr;
   logic [N_CH-1:0] w_exp_next;
   logic [7:0]      w_exp_rd;

   // Expiry is ORed in after the clear so a coincident expiry keeps its flag.
   always_comb begin
      w_exp_clr = '0;
      w_exp_rd  = '0;
      for (int c = 0; c < N_ST; c++) begin
         w_exp_clr[c] = w_wr && (w_dec.kind == REG_EXP) && write_value[c];
         w_exp_rd[c]  = r_exp[c];
      end
      w_exp_next = (r_exp & ~w_exp_clr) | w_expire;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_exp <= '0;
         irq   <= 1'b0;
      end else begin
         r_exp <= w_exp_next;
         irq   <= |w_exp_next;
      end
   end
`endif

   always_comb begin
      w_status = '0;
      for (int c = 0; c < N_ST; c++) begin
         w_status[c] = w_running[c];
      end
   end

   always_comb begin
      w_rdata = '0;
      case (w_dec.kind)
         REG_NOTE: begin
            for (int c = 0; c < N_CH; c++) begin
               if (w_dec.ch == 4'(c)) begin
                  w_rdata = r_note[c];
               end
            end
         end
         REG_DUR: begin
            for (int c = 0; c < N_CH; c++) begin
               if (w_dec.ch == 4'(c)) begin
                  w_rdata = 8'(r_dur[c]);
               end
            end
         end
         REG_STATUS: w_rdata = w_status;
         REG_CTRL:   w_rdata = r_ctrl;
`ifdef FLOPPY_REG_IRQ_EN
         REG_EXP:    w_rdata = w_exp_rd;
`endif
         default:    w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         read_value <= '0;
         read_valid <= 1'b0;
      end else begin
         read_valid <= w_rd;
         if (w_rd) begin
            read_value <= w_rdata;
         end
      end
   end

endmodule

// File: tb/tb_floppy_reg_bank.sv
// tb/tb_floppy_reg_bank.sv - self-checking bench for floppy_reg_bank
module tb_floppy_reg_bank;

   localparam int N_CH    = 4;
   localparam int CLK_HZ  = 1000;
   localparam int TICK_HZ = 100;
   localparam int DUR_W   = 8;
   localparam int DIV     = CLK_HZ / TICK_HZ;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [5:0]         reg_addr = '0;
   logic               write = 1'b0;
   logic               new_req = 1'b0;
   logic [7:0]         write_value = '0;
   logic [7:0]         read_value;
   logic               read_valid;
   logic [7:0]         led;
   logic [22*N_CH-1:0] f_sp;
   logic [N_CH-1:0]    f_en;
`ifdef FLOPPY_REG_IRQ_EN
   logic               irq;
`endif

   floppy_reg_bank #(
      .N_CH    (N_CH),
      .CLK_HZ  (CLK_HZ),
      .TICK_HZ (TICK_HZ),
      .DUR_W   (DUR_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .reg_addr    (reg_addr),
      .write       (write),
      .new_req     (new_req),
      .write_value (write_value),
      .read_value  (read_value),
      .read_valid  (read_valid),
      .led         (led),
      .f_sp        (f_sp),
      .f_en        (f_en)
`ifdef FLOPPY_REG_IRQ_EN
      ,
      .irq         (irq)
`endif
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string nm, input longint act, input longint expv);
      n_total++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
   endtask

   // Behavioural model: register contents, remaining ticks, running flags, expiry flags.
   logic [7:0] m_note [N_CH];
   logic [7:0] m_dur  [N_CH];
   int         m_cnt  [N_CH];
   bit         m_run  [N_CH];
   logic [7:0] m_ctrl;
   logic [7:0] m_exp;
   logic [7:0] m_rv;
   bit         m_rvalid;
   bit         m_irq;
   int         m_phase;
   int         edge_idx;
   bit         m_tick;
   logic [7:0] m_expd;

   function automatic logic [7:0] mread(input logic [5:0] a);
      int         ai;
      logic [7:0] s;
      ai = int'(a);
      s  = '0;
      if (ai < N_CH) return m_note[ai];
      if (ai >= 16 && ai < 16 + N_CH) return m_dur[ai-16];
      if (ai == 62) begin
         for (int c = 0; c < N_CH; c++) s[c] = m_run[c];
         return s;
      end
      if (ai == 63) return m_ctrl;
`ifdef FLOPPY_REG_IRQ_EN
      if (ai == 61) return m_exp;
`endif
      return 8'h00;
   endfunction

   function automatic real ideal_sp(input int n);
      return 25.0e6 / (440.0 * (2.0 ** ((n - 69) / 12.0)));
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < N_CH; c++) begin
            m_note[c] = 8'h00;
            m_dur[c]  = 8'h00;
            m_cnt[c]  = 0;
            m_run[c]  = 0;
         end
         m_ctrl = 8'h00; m_exp = 8'h00; m_rv = 8'h00; m_rvalid = 0; m_irq = 0;
         m_phase = 0; edge_idx = 0;
      end else begin
         m_tick   = (m_phase == DIV - 1);
         m_phase  = (m_phase + 1) % DIV;
         edge_idx = edge_idx + 1;
         m_rvalid = new_req && !write;
         if (m_rvalid) m_rv = mread(reg_addr);
         m_expd = 8'h00;
         for (int c = 0; c < N_CH; c++) begin
            if (new_req && write && int'(reg_addr) == c) begin
               m_note[c] = write_value;
               m_run[c]  = write_value[7] && (m_dur[c] != 0);
               if (m_run[c]) m_cnt[c] = int'(m_dur[c]);
            end else if (m_tick && m_run[c] && !m_ctrl[1]) begin
               m_cnt[c] = m_cnt[c] - 1;
               if (m_cnt[c] == 0) begin
                  m_run[c]     = 0;
                  m_note[c][7] = 1'b0;
                  m_expd[c]    = 1'b1;
               end
            end
         end
         for (int c = 0; c < N_CH; c++)
            if (new_req && write && int'(reg_addr) == 16 + c) m_dur[c] = write_value;
         if (new_req && write && reg_addr == 6'h3F) m_ctrl = write_value;
`ifdef FLOPPY_REG_IRQ_EN
         if (new_req && write && reg_addr == 6'h3D) m_exp = m_exp & ~write_value;
         m_exp = m_exp | m_expd;
         m_irq = (m_exp != 8'h00);
`endif
      end
   end

   logic [N_CH-1:0] c_en;
   real             c_id;
   real             c_got;

   always @(negedge clk) begin
      if (rst_n) begin
         check("cyc read_valid", read_valid, m_rvalid);
         check("cyc read_value", read_value, m_rv);
         for (int c = 0; c < N_CH; c++) c_en[c] = m_note[c][7] && !m_ctrl[0];
         check("cyc f_en", f_en, c_en);
         check("cyc led", led, m_note[0]);
`ifdef FLOPPY_REG_IRQ_EN
         check("cyc irq", irq, m_irq);
`endif
         for (int c = 0; c < N_CH; c++) begin
            c_id  = ideal_sp(int'(m_note[c][6:0]));
            c_got = real'(f_sp[c*22 +: 22]);
            n_total++;
            if ((c_got - c_id <= c_id / 2000.0 + 1.5) && (c_id - c_got <= c_id / 2000.0 + 1.5))
               n_pass++;
            else
               $display("FAIL cyc f_sp[%0d]: got %0d, expected about %0d", c, f_sp[c*22 +: 22], int'(c_id));
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic bus_wr(input logic [5:0] a, input logic [7:0] v);
      reg_addr = a; write = 1'b1; write_value = v; new_req = 1'b1;
      @(posedge clk); #1;
      new_req = 1'b0; write = 1'b0;
   endtask

   task automatic bus_rd(input logic [5:0] a, input logic [7:0] expv, input string nm);
      reg_addr = a; write = 1'b0; new_req = 1'b1;
      @(posedge clk); #1;
      new_req = 1'b0;
      check({nm, " valid"}, read_valid, 1);
      check(nm, read_value, expv);
   endtask

   task automatic align0();
      while (edge_idx % DIV != 0) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic scan_zero(input string nm);
      for (int a = 0; a < 64; a++) bus_rd(6'(a), 8'h00, nm);
   endtask

   initial begin
      #1;
      idle(3);
      check("reset read_value", read_value, 0);
      check("reset read_valid", read_valid, 0);
      check("reset f_en", f_en, 0);
      check("reset led", led, 0);
      rst_n = 1'b1;
      scan_zero("post-reset read");

      bus_wr(6'h02, 8'hC5);
      bus_rd(6'h02, 8'hC5, "note2 readback");
      check("note2 f_en", f_en[2], 1);
      check("note2 f_sp A4", f_sp[2*22 +: 22], 56818);

      bus_wr(6'h11, 8'd3);
      align0();
      bus_wr(6'h01, 8'hBC);
      check("note1 f_sp C4", f_sp[1*22 +: 22], 95556);
      idle(28);
      check("ch1 before 3rd tick", f_en[1], 1);
      idle(1);
      check("ch1 at 3rd tick", f_en[1], 0);
      bus_rd(6'h01, 8'h3C, "note1 after expiry");

      align0();
      bus_wr(6'h01, 8'hBC);
      idle(28);
      bus_wr(6'h01, 8'hBC);
      check("retrigger keeps enable", f_en[1], 1);
      idle(29);
      check("retrigger before reload expiry", f_en[1], 1);
      idle(1);
      check("retrigger reload expiry", f_en[1], 0);
`ifdef FLOPPY_REG_IRQ_EN
      bus_wr(6'h3D, 8'hFF);
      check("exp cleared irq", irq, 0);
`endif

      bus_wr(6'h3F, 8'h01);
      check("mute f_en", f_en, 0);
      bus_rd(6'h02, 8'hC5, "note2 under mute");
      bus_wr(6'h3F, 8'hA4);
      bus_rd(6'h3F, 8'hA4, "ctrl readback");
      bus_wr(6'h3F, 8'h00);
      check("unmute f_en2", f_en[2], 1);

      bus_wr(6'h13, 8'd2);
      bus_wr(6'h03, 8'h90);
      bus_wr(6'h10, 8'd5);
      align0();
      bus_wr(6'h00, 8'h85);
      idle(19);
      bus_wr(6'h3F, 8'h02);
      bus_rd(6'h3E, 8'h01, "status frozen");
      bus_wr(6'h10, 8'h20);
      idle(37);
      bus_wr(6'h3F, 8'h00);
      idle(28);
      check("ch0 resumed before expiry", f_en[0], 1);
      idle(1);
      check("ch0 resumed expiry", f_en[0], 0);
      bus_rd(6'h00, 8'h05, "note0 after expiry");
`ifdef FLOPPY_REG_IRQ_EN
      check("irq after ch0/ch3", irq, 1);
      bus_rd(6'h3D, 8'h09, "exp ch0 ch3");
      bus_wr(6'h3D, 8'h01);
      bus_rd(6'h3D, 8'h08, "exp after clear0");
      check("irq after clear0", irq, 1);
      bus_wr(6'h3D, 8'h08);
      check("irq after clear3", irq, 0);
      align0();
      bus_wr(6'h03, 8'h90);
      idle(18);
      bus_wr(6'h3D, 8'h08);
      bus_rd(6'h3D, 8'h08, "exp set beats clear");
      check("irq set beats clear", irq, 1);
      bus_wr(6'h3D, 8'h08);
`else
      bus_rd(6'h3D, 8'h00, "0x3D unmapped");
`endif

      bus_wr(6'h01, 8'hBC);
      bus_rd(6'h02, 8'hC5, "note2 before reset");
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("async reset f_en", f_en, 0);
      check("async reset read_value", read_value, 0);
      check("async reset read_valid", read_valid, 0);
      check("async reset led", led, 0);
      idle(3);
      rst_n = 1'b1;
      scan_zero("after mid-run reset");

      idle(2);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, %0d/%0d so far", n_pass, n_total);
      $fatal(1);
   end

endmodule

// File: doc/floppy_reg_bank.md
Name: floppy_reg_bank

Overview:
- Register bank for the MIDI-floppy player, generalised to N_CH floppy channels.
- Sits behind the byte-wide register bus. Holds a note/enable register per channel and a per-channel note-duration auto-off timer, plus global control and status registers.
- Drives per-channel step-period setpoints and enables to the floppy drivers.
- Each channel's setpoint comes from its own floppy_lookup instance.

Parameters:
- N_CH, 4, number of floppy channels (1..16).
- CLK_HZ, 50000000, system clock frequency.
- TICK_HZ, 1000, duration timer tick rate (1 ms default).
- DUR_W, 8, duration counter width in ticks.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- reg_addr  input  6  register address
- write  input  1  1 = write, 0 = read; qualified by new_req
- new_req  input  1  single-cycle request strobe
- write_value  input  8  write data
- read_value  output  8  read data, registered
- read_valid  output  1  pulses high the cycle read_value updates
- led  output  8  channel-0 note register
- f_sp  output  22*N_CH  setpoints; channel c at bits [22c+21:22c]
- f_en  output  N_CH  per-channel enable, gated by global mute
- irq  output  1  only with FLOPPY_REG_IRQ_EN; else port absent

Behaviour:
- Reset is asynchronous on rst_n low. Reset values:
  - all note registers 8'h00 (enable clear, note 0);
  - durations 0; counters 0; control 8'h00;
  - read_value 0, read_valid 0, prescaler 0, irq 0.
- Address map:
  - 0x00..N_CH-1: NOTE[c], bit7 = enable, bits6:0 = MIDI note.
  - 0x10..0x10+N_CH-1: DUR[c], duration in ticks; low DUR_W bits, upper bits read 0.
  - 0x3E: STATUS, read-only. Bit c = channel c timer running (N_CH≤8). Writes ignored.
  - 0x3F: CTRL. Bit0 = global mute (forces f_en=0, registers unchanged). Bit1 = timer freeze. Other bits read back as written.
  - Unmapped addresses: writes ignored, reads return 8'h00 with read_valid.
- Reads: one-cycle latency. new_req&!write in cycle t gives read_value and read_valid in t+1. read_value holds until the next read.
- Writes take effect at the clock edge of the new_req cycle; a read of the same register in t+1 returns the new value.
- Prescaler: counts 0..CLK_HZ/TICK_HZ-1, emits a 1-cycle tick at wrap. Runs continuously; CTRL bit1 does not stop it.
- Per-channel timer. Writing NOTE[c] with bit7=1:
  - if DUR[c]≠0, load cnt[c]=DUR[c] and mark running;
  - if DUR[c]=0, the note sustains with no timer.
- Writing NOTE[c] with bit7=0 clears running.
- On tick, if running and CTRL bit1=0, cnt decrements. At 1→0, NOTE[c] bit7 clears in the same edge and running clears; the note bits are kept.
- Simultaneous NOTE[c] write and expiry in the same cycle: the write wins (retrigger).
- Writing DUR[c] while running does not affect the current count.
- f_sp[c] is combinational from NOTE[c][6:0] through floppy_lookup. f_en[c] = NOTE[c][7] & !CTRL[0].

Optional Feature:
- Macro: FLOPPY_REG_IRQ_EN.
- With it defined:
  - each timer expiry sets sticky EXP[c];
  - EXP is readable at 0x3D, and writing 1 to bit c clears it (write-1-to-clear);
  - expiry in the same cycle as a clear wins, so the bit stays set;
  - irq = |EXP, registered, reset 0.
- Without it: no EXP register, no irq port, and 0x3D is unmapped.

Decomposition:
- Package floppy_reg_pkg holds:
  - address constants ADDR_NOTE_BASE, ADDR_DUR_BASE, ADDR_EXP, ADDR_STATUS, ADDR_CTRL;
  - CTRL bit indices;
  - setpoint width constant SP_W=22.
- Natural sub-module: floppy_note_timer, one per channel. It holds the counter, running flag and expire pulse, driven by tick, load, clear and freeze.
- floppy_lookup is reused unchanged, N_CH instances.

Test Plan:
- Reset: hold rst_n low mid-run with a timer running → f_en=0, read_value=0, and reads of every register return 8'h00 after release.
- Write 0x02←8'hC5, read 0x02 → read_valid one cycle later with 8'hC5; f_en[2]=1; f_sp[2] equals floppy_lookup(0x45).
- DUR[1]←3, NOTE[1]←8'h80|60, TICK_HZ scaled so one tick = 10 clk → f_en[1] falls exactly at the 3rd tick edge; NOTE[1] reads 8'h3C.
- Retrigger: NOTE[1] write on the same cycle as expiry → enable stays 1, counter reloads to DUR[1].
- CTRL←8'h01 → all f_en=0 while NOTE registers are unchanged. CTRL←8'h02 freezes the countdown; clearing the bit resumes from the held count.
- FLOPPY_REG_IRQ_EN: expiry on ch0 and ch3 → irq=1, 0x3D reads 8'h09. Write 8'h01 → reads 8'h08, irq stays 1. Write 8'h08 → irq=0.
